psum_channel_accumulator: RTL and testbench

- Downstream of the convolution layer block. Once the layer block pulses o_done, this block drains the per-input-channel partial-sum output BRAMs.
- For every (output channel, PE) lane it sums the IN_FM_CH partial sums, adds a per-output-channel bias, applies optional ReLU and saturates to the 30-bit feature-map width.
- Results leave as a valid/ready stream that feeds the next layer's feature-map BRAM loader.

---
 rtl/psum_channel_accumulator.sv | 191 +++++++++++++++++++
 tb/tb_psum_channel_accumulator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_channel_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_channel_accumulator
// Brief    : Drains the per-input-channel partial-sum BRAMs of the conv layer.
//            Each (output channel, PE) lane sums IN_FM_CH partial sums, adds the
//            output-channel bias, applies optional ReLU, saturates to OUT_W and
//            streams the word out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module psum_channel_accumulator #(
  parameter int NUM_PE     = 2,
  parameter int IN_FM_CH   = 3,
  parameter int OUT_FM_CH  = 2,
  parameter int DEPTH_MAIN = 250,
  parameter int DEPTH_LAST = 250,
  parameter int IN_W       = 48,
  parameter int OUT_W      = 30,
  parameter int BIAS_W     = 18,
  parameter int RELU       = 1,
  localparam int N_WORDS   = (NUM_PE == 1) ? DEPTH_MAIN :
                             ((DEPTH_MAIN > DEPTH_LAST) ? DEPTH_MAIN : DEPTH_LAST),
  localparam int AW        = $clog2(N_WORDS) + 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_start,
  input  logic [OUT_FM_CH*BIAS_W-1:0]            i_bias,
  input  logic [IN_FM_CH*OUT_FM_CH*NUM_PE*IN_W-1:0] i_psum_data,
  output logic [AW-1:0]                          o_bram_r_addr,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [OUT_FM_CH*NUM_PE*OUT_W-1:0]      o_data,
  output logic [NUM_PE-1:0]                      o_lane_mask,
  output logic [AW-1:0]                          o_word_idx,
  output logic                                   o_busy,
  output logic                                   o_done
);

  // Accumulator is wide enough for IN_FM_CH psums plus one bias term.
  localparam int c_acc_w = IN_W + $clog2(IN_FM_CH + 1);

  localparam logic [AW-1:0] c_last_addr  = AW'(N_WORDS - 1);
  localparam logic [AW-1:0] c_depth_main = AW'(DEPTH_MAIN);
  localparam logic [AW-1:0] c_depth_last = AW'((NUM_PE == 1) ? DEPTH_MAIN : DEPTH_LAST);

  localparam logic signed [c_acc_w-1:0] c_pos_max =
    {{(c_acc_w-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_neg_min =
    {{(c_acc_w-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [AW-1:0]                   r_issue_addr;
  logic [AW-1:0]                   r_fetch_addr;
  logic                            r_fetch_vld;
  logic [OUT_FM_CH*BIAS_W-1:0]     r_bias;
  logic                            w_stall;
  logic                            w_out_free;
  logic                            w_issue;
  logic                            w_start_acc;
  logic                            w_last_xfer;
  logic [NUM_PE-1:0]               w_mask;
  logic [OUT_FM_CH*NUM_PE*OUT_W-1:0] w_data;

  assign w_stall     = o_valid & ~i_ready;
  assign w_out_free  = ~w_stall;
  assign w_issue     = (r_state == S_RUN) & w_out_free;
  assign w_start_acc = (r_state == S_IDLE) & i_start;
  assign w_last_xfer = (r_state == S_DRAIN) & ~r_fetch_vld & o_valid & i_ready;

  // While stalled, re-drive the already fetched address so its data is still
  // present on i_psum_data when the output register frees up.
  assign o_bram_r_addr = w_stall ? r_fetch_addr : r_issue_addr;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN: begin
        o_busy = 1'b1;
        if (w_issue && (r_issue_addr == c_last_addr)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_last_xfer) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue address and bias capture; the address parks at the last word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_issue_addr <= '0;
      r_bias       <= '0;
    end else if (w_start_acc) begin
      r_issue_addr <= '0;
      r_bias       <= i_bias;
    end else if (w_issue && (r_issue_addr != c_last_addr)) begin
      r_issue_addr <= r_issue_addr + AW'(1);
    end
  end

  // Fetch stage: tracks which address's data is on i_psum_data this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_vld  <= 1'b0;
      r_fetch_addr <= '0;
    end else if (w_out_free) begin
      r_fetch_vld <= w_issue;
      if (w_issue) r_fetch_addr <= r_issue_addr;
    end
  end

  // Output stage: loads a new word whenever the previous one is gone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_lane_mask <= '0;
      o_word_idx  <= '0;
    end else if (w_out_free) begin
      o_valid <= r_fetch_vld;
      if (r_fetch_vld) begin
        o_data      <= w_data;
        o_lane_mask <= w_mask;
        o_word_idx  <= r_fetch_addr;
      end
    end
  end

  // Per-PE validity of the word being fetched; the last PE has its own depth.
  for (genvar gp = 0; gp < NUM_PE; gp++) begin : g_mask
    if (gp == NUM_PE - 1) begin : g_last
      assign w_mask[gp] = (r_fetch_addr < c_depth_last);
    end else begin : g_main
      assign w_mask[gp] = (r_fetch_addr < c_depth_main);
    end
  end

  for (genvar go = 0; go < OUT_FM_CH; go++) begin : g_och
    for (genvar gp = 0; gp < NUM_PE; gp++) begin : g_pe
      logic signed [c_acc_w-1:0] w_acc;
      logic [OUT_W-1:0]          w_res;

      // Sign-extended sum of bias and all input-channel partial sums.
      always_comb begin
        w_acc = {{(c_acc_w-BIAS_W){r_bias[go*BIAS_W+BIAS_W-1]}},
                 r_bias[go*BIAS_W +: BIAS_W]};
        for (int c = 0; c < IN_FM_CH; c++) begin
          w_acc = w_acc +
            {{(c_acc_w-IN_W){i_psum_data[((c*OUT_FM_CH+go)*NUM_PE+gp)*IN_W+IN_W-1]}},
             i_psum_data[((c*OUT_FM_CH+go)*NUM_PE+gp)*IN_W +: IN_W]};
        end
      end

      // ReLU clamp, then saturate to the feature-map width.
      always_comb begin
        if ((RELU != 0) && w_acc[c_acc_w-1]) w_res = '0;
        else if (w_acc > c_pos_max)          w_res = c_pos_max[OUT_W-1:0];
        else if (w_acc < c_neg_min)          w_res = c_neg_min[OUT_W-1:0];
        else                                 w_res = w_acc[OUT_W-1:0];
      end

      assign w_data[(go*NUM_PE+gp)*OUT_W +: OUT_W] = w_mask[gp] ? w_res : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_channel_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_channel_accumulator
// Brief    : Directed bench for psum_channel_accumulator. Three instances cover
//            RELU=1 / RELU=0 and unequal BRAM depths; a shared BRAM model
//            serves whichever instance is selected.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_channel_accumulator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [35:0]  bias;
  logic [575:0] psum;
  int           sel;
  int           mode;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  logic [2:0]   a_addr, a_idx, n_addr, n_idx;
  logic [3:0]   u_addr, u_idx;
  logic         a_valid, a_busy, a_done, n_valid, n_busy, n_done, u_valid, u_busy, u_done;
  logic [119:0] a_data, n_data, u_data;
  logic [1:0]   a_mask, n_mask, u_mask;

  psum_channel_accumulator #(.NUM_PE(2), .IN_FM_CH(3), .OUT_FM_CH(2), .DEPTH_MAIN(4),
    .DEPTH_LAST(4), .IN_W(48), .OUT_W(30), .BIAS_W(18), .RELU(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 0)), .i_bias(bias),
    .i_psum_data(psum), .o_bram_r_addr(a_addr), .o_valid(a_valid), .i_ready(ready),
    .o_data(a_data), .o_lane_mask(a_mask), .o_word_idx(a_idx), .o_busy(a_busy),
    .o_done(a_done));

  psum_channel_accumulator #(.NUM_PE(2), .IN_FM_CH(3), .OUT_FM_CH(2), .DEPTH_MAIN(4),
    .DEPTH_LAST(4), .IN_W(48), .OUT_W(30), .BIAS_W(18), .RELU(0)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 1)), .i_bias(bias),
    .i_psum_data(psum), .o_bram_r_addr(n_addr), .o_valid(n_valid), .i_ready(ready),
    .o_data(n_data), .o_lane_mask(n_mask), .o_word_idx(n_idx), .o_busy(n_busy),
    .o_done(n_done));

  psum_channel_accumulator #(.NUM_PE(2), .IN_FM_CH(3), .OUT_FM_CH(2), .DEPTH_MAIN(5),
    .DEPTH_LAST(3), .IN_W(48), .OUT_W(30), .BIAS_W(18), .RELU(1)) dut_u (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 2)), .i_bias(bias),
    .i_psum_data(psum), .o_bram_r_addr(u_addr), .o_valid(u_valid), .i_ready(ready),
    .o_data(u_data), .o_lane_mask(u_mask), .o_word_idx(u_idx), .o_busy(u_busy),
    .o_done(u_done));

  logic [3:0]   cur_addr, cur_idx;
  logic         cur_valid, cur_busy, cur_done;
  logic [119:0] cur_data;
  logic [1:0]   cur_mask;

  // View of the currently selected instance.
  always_comb begin
    case (sel)
      1: begin
        cur_addr = {1'b0, n_addr}; cur_idx = {1'b0, n_idx}; cur_valid = n_valid;
        cur_busy = n_busy; cur_done = n_done; cur_data = n_data; cur_mask = n_mask;
      end
      2: begin
        cur_addr = u_addr; cur_idx = u_idx; cur_valid = u_valid;
        cur_busy = u_busy; cur_done = u_done; cur_data = u_data; cur_mask = u_mask;
      end
      default: begin
        cur_addr = {1'b0, a_addr}; cur_idx = {1'b0, a_idx}; cur_valid = a_valid;
        cur_busy = a_busy; cur_done = a_done; cur_data = a_data; cur_mask = a_mask;
      end
    endcase
  end

  // Partial-sum pattern for lane (c,o,p) at BRAM address a.
  function automatic logic [575:0] build(input int m, input int a);
    logic [575:0] r;
    longint       v;
    r = '0;
    for (int c = 0; c < 3; c++)
      for (int o = 0; o < 2; o++)
        for (int p = 0; p < 2; p++) begin
          case (m)
            0:       v = longint'(c + 1);
            1:       v = longint'(c + 1 + 100 * a + 1000 * p);
            2:       v = -5;
            3:       v = longint'(1) <<< 40;
            default: v = -(longint'(1) <<< 40);
          endcase
          r[((c*2+o)*2+p)*48 +: 48] = v[47:0];
        end
    return r;
  endfunction

  // Synchronous-read BRAM model, one cycle latency.
  always @(posedge clk) psum <= build(mode, int'(cur_addr));

  function automatic logic [119:0] pack(input longint l00, input longint l01,
                                        input longint l10, input longint l11);
    logic [119:0] r;
    r[29:0]   = l00[29:0];
    r[59:30]  = l01[29:0];
    r[89:60]  = l10[29:0];
    r[119:90] = l11[29:0];
    return r;
  endfunction

  function automatic logic [35:0] mkbias(input longint b0, input longint b1);
    logic [35:0] r;
    r[17:0]  = b0[17:0];
    r[35:18] = b1[17:0];
    return r;
  endfunction

  // Expected word for mode-1 data: lane sum is 6 + 300*a + 3000*p + bias(o).
  function automatic logic [119:0] expw(input int a, input bit full,
                                        input longint b0, input longint b1);
    longint base;
    base = longint'(6 + 300 * a);
    return pack(base + b0, full ? base + 3000 + b0 : 0,
                base + b1, full ? base + 3000 + b1 : 0);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a job, check its first word, then wait for completion.
  task automatic run_first(input string tag, input logic [119:0] exp);
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (cur_valid) seen = 1'b1;
      else step();
    end
    check({tag, "_valid"}, seen, 1);
    check({tag, "_data"}, cur_data, exp);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (cur_done) seen = 1'b1;
      else step();
    end
    check({tag, "_done"}, seen, 1);
    step();
  endtask

  initial begin
    bit           done_seen;
    bit           prev_stall;
    bit           seen;
    int           nx;
    int           s1;
    logic [119:0] pdata;
    logic [3:0]   pidx;

    rst_n = 1'b0; start = 1'b0; ready = 1'b1; bias = '0; sel = 0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", cur_valid, 0);
    check("rst_busy", cur_busy, 0);
    check("rst_done", cur_done, 0);
    check("rst_data", cur_data, 0);
    check("rst_mask", cur_mask, 0);
    check("rst_idx", cur_idx, 0);
    rst_n = 1'b1;
    step();

    // Basic run plus spurious starts in RUN and DONE with a different bias.
    sel = 0; mode = 0; bias = mkbias(10, -2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("basic_busy", cur_busy, 1);
    check("basic_addr0", cur_addr, 0);
    check("basic_valid_e0", cur_valid, 0);
    step();
    check("basic_valid_e1", cur_valid, 0);
    start = 1'b1;
    bias  = mkbias(99, 99);
    step();
    start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check("basic_valid", cur_valid, 1);
      check("basic_idx", cur_idx, 4'(w));
      check("basic_mask", cur_mask, 2'b11);
      check("basic_data", cur_data, pack(16, 16, 4, 4));
      step();
    end
    check("basic_done", cur_done, 1);
    check("basic_valid_off", cur_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("basic_done_pulse", cur_done, 0);
    check("basic_idle", cur_busy, 0);
    step();
    check("spur_start_busy", cur_busy, 0);
    check("spur_start_valid", cur_valid, 0);

    // ReLU and saturation.
    bias = mkbias(0, 0);
    mode = 2;
    run_first("relu_neg", pack(0, 0, 0, 0));
    mode = 3;
    run_first("sat_pos", pack(536870911, 536870911, 536870911, 536870911));
    sel = 1; mode = 4;
    run_first("sat_neg", pack(-536870912, -536870912, -536870912, -536870912));

    // Backpressure: three-cycle stall on word 1, then alternating ready.
    sel = 0; mode = 1; bias = mkbias(10, -2); ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    nx = 0; s1 = 0; prev_stall = 1'b0; done_seen = 1'b0; pdata = '0; pidx = '0;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      if (cur_done) done_seen = 1'b1;
      if (prev_stall) begin
        check("bp_hold_valid", cur_valid, 1);
        check("bp_hold_data", cur_data, pdata);
        check("bp_hold_idx", cur_idx, pidx);
      end
      if (cur_valid && cur_idx == 4'd1 && s1 < 3) begin
        ready = 1'b0;
        s1++;
      end else if (cur_valid && cur_idx >= 4'd2) begin
        ready = cyc[0];
      end else begin
        ready = 1'b1;
      end
      #1;
      if (cur_valid && !ready) begin
        prev_stall = 1'b1;
        pdata      = cur_data;
        pidx       = cur_idx;
        if (cur_idx < 4'd3) check("bp_readdr", cur_addr, cur_idx + 4'd1);
      end else begin
        prev_stall = 1'b0;
      end
      if (cur_valid && ready) begin
        check("bp_idx", cur_idx, 4'(nx));
        check("bp_data", cur_data, expw(nx, 1'b1, 10, -2));
        nx++;
      end
      step();
    end
    ready = 1'b1;
    check("bp_count", nx, 4);
    check("bp_stalls", s1, 3);
    check("bp_done", done_seen, 1);
    step();

    // Unequal depths: last PE holds only three words.
    sel = 2; mode = 1; bias = mkbias(10, -2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int w = 0; w < 5; w++) begin
      check("ud_valid", cur_valid, 1);
      check("ud_idx", cur_idx, 4'(w));
      check("ud_mask", cur_mask, (w < 3) ? 2'b11 : 2'b01);
      check("ud_data", cur_data, expw(w, w < 3, 10, -2));
      step();
    end
    check("ud_done", cur_done, 1);
    step();

    // Asynchronous reset while word 2 is presented, then a fresh job.
    sel = 0; mode = 1; bias = mkbias(10, -2);
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (cur_valid && cur_idx == 4'd2) seen = 1'b1;
      else step();
    end
    check("rr_reach_w2", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_valid", cur_valid, 0);
    check("rr_busy", cur_busy, 0);
    check("rr_done", cur_done, 0);
    check("rr_addr", cur_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bias  = mkbias(7, 5);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rr_replay_valid", cur_valid, 1);
    check("rr_replay_idx", cur_idx, 0);
    check("rr_replay_data", cur_data, pack(13, 3013, 11, 3011));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (cur_done) seen = 1'b1;
      else step();
    end
    check("rr_replay_done", seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
